// File: rtl/cpu_pkg.sv
// Shared pipeline encodings: ALU operation codes, forwarding source selects
// and the hard-wired zero register number.
package cpu_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_AND = 3'b001,
      ALU_XOR = 3'b010,
      ALU_SLL = 3'b011,
      ALU_SUB = 3'b100,
      ALU_OR  = 3'b101,
      ALU_SRL = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_EX  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding for one source register: picks the youngest in-flight
// producer (EX, then MEM) or falls back to the register-file read.
module fwd_unit
   import cpu_pkg::*;
(
   input  logic [4:0]  src,
   input  logic [31:0] rf_data,
   input  logic        e_valid,
   input  logic        e_wreg,
   input  logic        e_m2reg,
   input  logic [4:0]  e_rn,
   input  logic [31:0] e_alu_r,
   input  logic        m_valid,
   input  logic        m_wreg,
   input  logic        m_m2reg,
   input  logic [4:0]  m_rn,
   input  logic [31:0] m_alu,
   input  logic [31:0] m_mdata,
   output logic [31:0] data
);

   fwd_sel_e sel;
   logic     ex_hit;
   logic     mem_hit;

   // A load in EX has no result yet; that case is resolved by stalling instead.
   assign ex_hit  = e_valid & e_wreg & ~e_m2reg & (e_rn == src) & (src != REG_ZERO);
   assign mem_hit = m_valid & m_wreg & (m_rn == src) & (src != REG_ZERO);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      sel = FWD_REG;
      if (ex_hit)
         sel = FWD_EX;
      else if (mem_hit)
         sel = FWD_MEM;
   end

   always_comb begin
      data = rf_data;
      unique case (sel)
         FWD_EX:  data = e_alu_r;
         FWD_MEM: data = m_m2reg ? m_mdata : m_alu;
         default: data = rf_data;
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall detection
// and bubble insertion on stall or branch flush.
module id_ex_stage
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        clrn,
   input  logic        d_valid,
   input  logic        d_wreg,
   input  logic        d_m2reg,
   input  logic        d_wmem,
   input  logic        d_jal,
   input  logic        d_aluimm,
   input  logic        d_shift,
   input  logic [2:0]  d_aluc,
   input  logic [4:0]  d_rs,
   input  logic [4:0]  d_rt,
   input  logic        d_use_rs,
   input  logic        d_use_rt,
   input  logic [4:0]  d_rn,
   input  logic [31:0] d_qa,
   input  logic [31:0] d_qb,
   input  logic [31:0] d_imm,
   input  logic [31:0] d_pc4,
   input  logic [31:0] e_alu_r,
   input  logic        m_valid,
   input  logic        m_wreg,
   input  logic        m_m2reg,
   input  logic [4:0]  m_rn,
   input  logic [31:0] m_alu,
   input  logic [31:0] m_mdata,
   input  logic        flush,
   output logic        stall,
   output logic        e_valid,
   output logic        e_wreg,
   output logic        e_m2reg,
   output logic        e_wmem,
   output logic        e_jal,
   output logic [2:0]  e_aluc,
   output logic [31:0] e_a,
   output logic [31:0] e_b,
   output logic [31:0] e_qb,
   output logic [4:0]  e_rn,
   output logic [31:0] e_pc4,
   output logic [15:0] bubble_cnt
);

   logic [31:0] fa;
   logic [31:0] fb;
   logic [31:0] a_next;
   logic [31:0] b_next;
   logic        bubble;

   fwd_unit u_fwd_rs (
      .src(d_rs), .rf_data(d_qa),
      .e_valid(e_valid), .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_rn(e_rn), .e_alu_r(e_alu_r),
      .m_valid(m_valid), .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_rn(m_rn),
      .m_alu(m_alu), .m_mdata(m_mdata), .data(fa)
   );

   fwd_unit u_fwd_rt (
      .src(d_rt), .rf_data(d_qb),
      .e_valid(e_valid), .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_rn(e_rn), .e_alu_r(e_alu_r),
      .m_valid(m_valid), .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_rn(m_rn),
      .m_alu(m_alu), .m_mdata(m_mdata), .data(fb)
   );

   // Load in EX whose destination is read by the ID instruction: wait one cycle.
   assign stall = d_valid & e_valid & e_wreg & e_m2reg & (e_rn != REG_ZERO) &
                  ((d_use_rs & (e_rn == d_rs)) | (d_use_rt & (e_rn == d_rt)));
   assign bubble = stall | flush;

   assign a_next = d_shift  ? {27'b0, d_imm[10:6]} : fa;
   assign b_next = d_aluimm ? d_imm : fb;

   always_ff @(posedge clk or negedge clrn) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!clrn) begin
         e_valid    <= 1'b0;
         e_wreg     <= 1'b0;
         e_m2reg    <= 1'b0;
         e_wmem     <= 1'b0;
         e_jal      <= 1'b0;
         e_aluc     <= '0;
         e_a        <= '0;
         e_b        <= '0;
         e_qb       <= '0;
         e_rn       <= '0;
         e_pc4      <= '0;
         bubble_cnt <= '0;
      end else if (bubble) begin
         e_valid <= 1'b0;
         e_wreg  <= 1'b0;
         e_m2reg <= 1'b0;
         e_wmem  <= 1'b0;
         e_jal   <= 1'b0;
         e_aluc  <= '0;
         e_a     <= '0;
         e_b     <= '0;
         e_qb    <= '0;
         e_rn    <= '0;
         e_pc4   <= '0;
         if (bubble_cnt != 16'hFFFF)
            bubble_cnt <= bubble_cnt + 16'd1;
      end else begin
         // An invalid ID slot still advances, but with every side effect masked.
         e_valid <= d_valid;
         e_wreg  <= d_valid & d_wreg;
         e_m2reg <= d_valid & d_m2reg;
         e_wmem  <= d_valid & d_wmem;
         e_jal   <= d_valid & d_jal;
         e_aluc  <= d_aluc;
         e_a     <= a_next;
         e_b     <= b_next;
         e_qb    <= fb;
         e_rn    <= d_rn;
         e_pc4   <= d_pc4;
      end
   end

endmodule
